// File: rtl/bar_sprite_engine.sv
// Bar sprite engine: N_BARS vertical bars whose top-edge y is written by a custom
// instruction and committed at frame start, with a one-cycle registered pixel path.
module bar_sprite_engine #(
  parameter int                   N_BARS    = 2,
  parameter int                   BAR_W     = 10,
  parameter int                   BAR_H     = 30,
  parameter logic [11*N_BARS-1:0] X_POS     = {11'd620, 11'd10},
  parameter int                   Y_INIT    = 285,
  parameter int                   Y_MAX     = 450,
  parameter int                   SLEW_MODE = 0,
  parameter int                   STEP      = 4
) (
  input  logic              clk_in,
  input  logic              i_rst,
  input  logic              clk_en,
  input  logic [2:0]        sel,
  input  logic [9:0]        coordY,
  input  logic              frame_start,
  input  logic              o_active,
  input  logic [10:0]       o_x,
  input  logic [9:0]        o_y,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [N_BARS-1:0] pending,
  output logic              color,
  output logic [2:0]        bar_hit
);

  localparam logic [9:0]  Y_INIT10 = 10'(Y_INIT);
  localparam logic [9:0]  Y_MAX10  = 10'(Y_MAX);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [11:0] BAR_W12  = 12'(BAR_W);
  localparam logic [11:0] BAR_H12  = 12'(BAR_H);
  localparam logic [3:0]  N_BARS4  = 4'(N_BARS);

  logic [9:0]        y_q      [N_BARS];
  logic [9:0]        target_q [N_BARS];
  logic [N_BARS-1:0] pending_q;

  logic [9:0]        next_y   [N_BARS];
  logic [N_BARS-1:0] next_done;
  logic [9:0]        diff;
  logic [9:0]        clamped;
  logic              sel_bad;

  assign pending = pending_q;
  assign sel_bad = ({1'b0, sel} >= N_BARS4);
  assign clamped = (coordY > Y_MAX10) ? Y_MAX10 : coordY;

  // Position each pending bar would take if a frame_start committed it now.
  always_comb begin
    diff      = '0;
    next_done = '0;
    for (int i = 0; i < N_BARS; i++) begin
      next_y[i] = target_q[i];
      if (SLEW_MODE != 0) begin
        if (target_q[i] > y_q[i]) begin
          diff      = target_q[i] - y_q[i];
          next_y[i] = y_q[i] + ((diff > STEP10) ? STEP10 : diff);
        end else begin
          diff      = y_q[i] - target_q[i];
          next_y[i] = y_q[i] - ((diff > STEP10) ? STEP10 : diff);
        end
      end
      next_done[i] = (next_y[i] == target_q[i]);
    end
  end

  // Hit test; widened to 12 bits so edge sums near the top of the range cannot wrap.
  logic [11:0] px, py, x0, y0;
  logic        hit_any;
  logic [2:0]  hit_idx;

  always_comb begin
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    px      = {1'b0, o_x};
    py      = {2'b0, o_y};
    x0      = '0;
    y0      = '0;
    hit_any = 1'b0;
    hit_idx = 3'd0;
    // Walk from the highest index down so the lowest overlapping bar wins.
    for (int i = N_BARS - 1; i >= 0; i--) begin
      x0 = {1'b0, X_POS[11*i +: 11]};
      y0 = {2'b0, y_q[i]};
      if (px >= x0 && px < x0 + BAR_W12 && py >= y0 && py < y0 + BAR_H12) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: the per-bar registers are a handful of flops, not a RAM, so resetting them is fine.
    if (i_rst) begin
      for (int i = 0; i < N_BARS; i++) begin
        y_q[i]      <= Y_INIT10;
        target_q[i] <= Y_INIT10;
      end
      pending_q <= '0;
      color     <= 1'b0;
      bar_hit   <= 3'd0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_ack  <= clk_en;
      wr_err  <= clk_en && sel_bad;
      color   <= o_active && hit_any;
      bar_hit <= (o_active && hit_any) ? hit_idx : 3'd0;
      for (int i = 0; i < N_BARS; i++) begin
        if (frame_start && pending_q[i]) begin
          y_q[i] <= next_y[i];
          if (next_done[i]) pending_q[i] <= 1'b0;
        end
        // A same-cycle write lands after the commit above, so it stays pending.
        if (clk_en && !sel_bad && sel == 3'(i)) begin
          target_q[i]  <= clamped;
          pending_q[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bar_sprite_engine.sv
// Directed bench: a jump-mode instance with default bars and a slew-mode instance
// whose two bars overlap, both driven from the same stimulus.
module tb_bar_sprite_engine;

  logic        clk_in = 1'b0;
  logic        i_rst, clk_en, frame_start, o_active;
  logic [2:0]  sel;
  logic [9:0]  coordY, o_y;
  logic [10:0] o_x;

  logic       wr_ack_j, wr_err_j, color_j;
  logic [1:0] pending_j;
  logic [2:0] bar_hit_j;
  logic       wr_ack_s, wr_err_s, color_s;
  logic [1:0] pending_s;
  logic [2:0] bar_hit_s;

  int cmps = 0;
  int errs = 0;

  always #5 clk_in = ~clk_in;

  bar_sprite_engine u_j (
    .clk_in(clk_in), .i_rst(i_rst), .clk_en(clk_en), .sel(sel), .coordY(coordY),
    .frame_start(frame_start), .o_active(o_active), .o_x(o_x), .o_y(o_y),
    .wr_ack(wr_ack_j), .wr_err(wr_err_j), .pending(pending_j),
    .color(color_j), .bar_hit(bar_hit_j)
  );

  bar_sprite_engine #(.SLEW_MODE(1), .STEP(4), .X_POS({11'd12, 11'd10})) u_s (
    .clk_in(clk_in), .i_rst(i_rst), .clk_en(clk_en), .sel(sel), .coordY(coordY),
    .frame_start(frame_start), .o_active(o_active), .o_x(o_x), .o_y(o_y),
    .wr_ack(wr_ack_s), .wr_err(wr_err_s), .pending(pending_s),
    .color(color_s), .bar_hit(bar_hit_s)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic act);
    logic [10:0] xv;
    logic [9:0]  yv;
    xv = 11'(x);
    yv = 10'(y);
    o_x = xv; o_y = yv; o_active = act;
    tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic write(input int s, input int cy);
    logic [2:0] sv;
    logic [9:0] cv;
    sv = 3'(s);
    cv = 10'(cy);
    sel = sv; coordY = cv; clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; clk_en = 1'b1; sel = 3'd0; coordY = 10'd50; frame_start = 1'b1;
    o_active = 1'b1; o_x = 11'd12; o_y = 10'd290;
    tick(); tick();
    i_rst = 1'b0; clk_en = 1'b0; frame_start = 1'b0; o_active = 1'b0;
    cmps++; if (pending_j !== 2'b00) begin errs++; $display("FAIL rst_pending: got %b want 00", pending_j); end
    cmps++; if (wr_ack_j !== 1'b0 || wr_err_j !== 1'b0) begin errs++; $display("FAIL rst_ack: got %b%b want 00", wr_ack_j, wr_err_j); end
    cmps++; if (color_j !== 1'b0 || bar_hit_j !== 3'd0) begin errs++; $display("FAIL rst_pix: got %b/%0d want 0/0", color_j, bar_hit_j); end
    pix(12, 290, 1'b1);
    cmps++; if (color_j !== 1'b1 || bar_hit_j !== 3'd0) begin errs++; $display("FAIL def_12_290: got %b/%0d want 1/0", color_j, bar_hit_j); end
    pix(12, 315, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL def_12_315: got %b want 0", color_j); end
    pix(12, 314, 1'b1);
    cmps++; if (color_j !== 1'b1) begin errs++; $display("FAIL def_12_314: got %b want 1", color_j); end
    pix(19, 285, 1'b1);
    cmps++; if (color_j !== 1'b1) begin errs++; $display("FAIL def_19_285: got %b want 1", color_j); end
    pix(20, 290, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL def_20_290: got %b want 0", color_j); end
    pix(9, 290, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL def_9_290: got %b want 0", color_j); end
    // Pipeline depth: the output must follow the previous cycle's pixel, not two back.
    pix(620, 300, 1'b1);
    cmps++; if (color_j !== 1'b1 || bar_hit_j !== 3'd1) begin errs++; $display("FAIL lat_bar1: got %b/%0d want 1/1", color_j, bar_hit_j); end
    pix(0, 0, 1'b1);
    cmps++; if (color_j !== 1'b0 || bar_hit_j !== 3'd0) begin errs++; $display("FAIL lat_miss: got %b/%0d want 0/0", color_j, bar_hit_j); end
  endtask

  task automatic test_write();
    write(1, 100);
    cmps++; if (wr_ack_j !== 1'b1 || wr_err_j !== 1'b0) begin errs++; $display("FAIL wr_ack: got %b%b want 10", wr_ack_j, wr_err_j); end
    cmps++; if (pending_j !== 2'b10) begin errs++; $display("FAIL wr_pending: got %b want 10", pending_j); end
    pix(625, 285, 1'b1);
    cmps++; if (wr_ack_j !== 1'b0) begin errs++; $display("FAIL wr_ack_pulse: got %b want 0", wr_ack_j); end
    cmps++; if (color_j !== 1'b1 || bar_hit_j !== 3'd1) begin errs++; $display("FAIL wr_hold_y: got %b/%0d want 1/1", color_j, bar_hit_j); end
    frame();
    cmps++; if (pending_j !== 2'b00) begin errs++; $display("FAIL commit_pending: got %b want 00", pending_j); end
    pix(625, 100, 1'b1);
    cmps++; if (color_j !== 1'b1 || bar_hit_j !== 3'd1) begin errs++; $display("FAIL commit_625_100: got %b/%0d want 1/1", color_j, bar_hit_j); end
    pix(625, 99, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL commit_625_99: got %b want 0", color_j); end
    pix(625, 285, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL commit_old_y: got %b want 0", color_j); end
  endtask

  task automatic test_clamp_err();
    write(0, 700);
    cmps++; if (pending_j !== 2'b01) begin errs++; $display("FAIL clamp_pending: got %b want 01", pending_j); end
    frame();
    pix(12, 450, 1'b1);
    cmps++; if (color_j !== 1'b1 || bar_hit_j !== 3'd0) begin errs++; $display("FAIL clamp_450: got %b/%0d want 1/0", color_j, bar_hit_j); end
    pix(12, 479, 1'b1);
    cmps++; if (color_j !== 1'b1) begin errs++; $display("FAIL clamp_479: got %b want 1", color_j); end
    pix(12, 449, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL clamp_449: got %b want 0", color_j); end
    pix(12, 480, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL clamp_480: got %b want 0", color_j); end
    write(5, 123);
    cmps++; if (wr_ack_j !== 1'b1 || wr_err_j !== 1'b1) begin errs++; $display("FAIL err_ack: got %b%b want 11", wr_ack_j, wr_err_j); end
    cmps++; if (pending_j !== 2'b00) begin errs++; $display("FAIL err_pending: got %b want 00", pending_j); end
    tick();
    cmps++; if (wr_err_j !== 1'b0) begin errs++; $display("FAIL err_pulse: got %b want 0", wr_err_j); end
  endtask

  task automatic test_overlap();
    do_reset();
    pix(13, 290, 1'b1);
    cmps++; if (color_s !== 1'b1 || bar_hit_s !== 3'd0) begin errs++; $display("FAIL overlap_low: got %b/%0d want 1/0", color_s, bar_hit_s); end
    pix(20, 290, 1'b1);
    cmps++; if (color_s !== 1'b1 || bar_hit_s !== 3'd1) begin errs++; $display("FAIL overlap_b1: got %b/%0d want 1/1", color_s, bar_hit_s); end
    pix(22, 290, 1'b1);
    cmps++; if (color_s !== 1'b0 || bar_hit_s !== 3'd0) begin errs++; $display("FAIL overlap_out: got %b/%0d want 0/0", color_s, bar_hit_s); end
  endtask

  task automatic test_slew();
    do_reset();
    write(0, 295);
    frame();
    cmps++; if (pending_s !== 2'b01) begin errs++; $display("FAIL slew1_pending: got %b want 01", pending_s); end
    cmps++; if (pending_j !== 2'b00) begin errs++; $display("FAIL jump_pending: got %b want 00", pending_j); end
    pix(10, 288, 1'b1);
    cmps++; if (color_s !== 1'b0) begin errs++; $display("FAIL slew1_288: got %b want 0", color_s); end
    pix(10, 289, 1'b1);
    cmps++; if (color_s !== 1'b1) begin errs++; $display("FAIL slew1_289: got %b want 1", color_s); end
    frame();
    cmps++; if (pending_s !== 2'b01) begin errs++; $display("FAIL slew2_pending: got %b want 01", pending_s); end
    pix(10, 292, 1'b1);
    cmps++; if (color_s !== 1'b0) begin errs++; $display("FAIL slew2_292: got %b want 0", color_s); end
    pix(10, 293, 1'b1);
    cmps++; if (color_s !== 1'b1) begin errs++; $display("FAIL slew2_293: got %b want 1", color_s); end
    frame();
    cmps++; if (pending_s !== 2'b00) begin errs++; $display("FAIL slew3_pending: got %b want 00", pending_s); end
    pix(10, 294, 1'b1);
    cmps++; if (color_s !== 1'b0) begin errs++; $display("FAIL slew3_294: got %b want 0", color_s); end
    pix(10, 295, 1'b1);
    cmps++; if (color_s !== 1'b1) begin errs++; $display("FAIL slew3_295: got %b want 1", color_s); end
  endtask

  task automatic test_collision();
    do_reset();
    write(0, 200);
    cmps++; if (pending_j !== 2'b01) begin errs++; $display("FAIL coll_pending0: got %b want 01", pending_j); end
    sel = 3'd0; coordY = 10'd50; clk_en = 1'b1; frame_start = 1'b1;
    tick();
    clk_en = 1'b0; frame_start = 1'b0;
    cmps++; if (pending_j !== 2'b01) begin errs++; $display("FAIL coll_pending1: got %b want 01", pending_j); end
    pix(12, 200, 1'b1);
    cmps++; if (color_j !== 1'b1) begin errs++; $display("FAIL coll_y200: got %b want 1", color_j); end
    pix(12, 50, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL coll_y50_early: got %b want 0", color_j); end
    frame();
    cmps++; if (pending_j !== 2'b00) begin errs++; $display("FAIL coll_pending2: got %b want 00", pending_j); end
    pix(12, 50, 1'b1);
    cmps++; if (color_j !== 1'b1) begin errs++; $display("FAIL coll_y50: got %b want 1", color_j); end
    pix(12, 200, 1'b1);
    cmps++; if (color_j !== 1'b0) begin errs++; $display("FAIL coll_y200_gone: got %b want 0", color_j); end
  endtask

  task automatic test_reset_mid_slew();
    do_reset();
    write(0, 400);
    frame();
    pix(10, 285, 1'b1);
    cmps++; if (color_s !== 1'b0) begin errs++; $display("FAIL mid_moved: got %b want 0", color_s); end
    do_reset();
    cmps++; if (pending_s !== 2'b00) begin errs++; $display("FAIL mid_pending: got %b want 00", pending_s); end
    pix(10, 285, 1'b1);
    cmps++; if (color_s !== 1'b1) begin errs++; $display("FAIL mid_285: got %b want 1", color_s); end
    pix(10, 284, 1'b1);
    cmps++; if (color_s !== 1'b0) begin errs++; $display("FAIL mid_284: got %b want 0", color_s); end
    frame();
    pix(10, 285, 1'b1);
    cmps++; if (color_s !== 1'b1) begin errs++; $display("FAIL mid_no_resume: got %b want 1", color_s); end
    pix(12, 290, 1'b0);
    cmps++; if (color_j !== 1'b0 || bar_hit_j !== 3'd0) begin errs++; $display("FAIL blank_j: got %b/%0d want 0/0", color_j, bar_hit_j); end
    cmps++; if (color_s !== 1'b0 || bar_hit_s !== 3'd0) begin errs++; $display("FAIL blank_s: got %b/%0d want 0/0", color_s, bar_hit_s); end
  endtask

  initial begin
    i_rst = 1'b0; clk_en = 1'b0; frame_start = 1'b0; o_active = 1'b0;
    sel = 3'd0; coordY = 10'd0; o_x = 11'd0; o_y = 10'd0;
    test_reset();
    test_write();
    test_clamp_err();
    test_overlap();
    test_slew();
    test_collision();
    test_reset_mid_slew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/bar_sprite_engine.md
BAR_SPRITE_ENGINE -- requirements
Module: bar_sprite_engine

Interface
REQ-001 Parameter N_BARS, default 2: number of independent bars, range 1..8.
REQ-002 Parameter BAR_W, default 10: bar width in pixels.
REQ-003 Parameter BAR_H, default 30: bar height in pixels.
REQ-004 Parameter X_POS, default {11'd620, 11'd10}: packed N_BARS x 11-bit left-edge x per bar; bar i uses bits [11*i+10:11*i].
REQ-005 Parameter Y_INIT, default 285: initial top-edge y of every bar.
REQ-006 Parameter Y_MAX, default 450: largest legal top-edge y.
REQ-007 Parameter SLEW_MODE, default 0: 0 = jump to target, 1 = move at most STEP px per frame.
REQ-008 Parameter STEP, default 4: per-frame slew limit in px, range 1..Y_MAX.
REQ-009 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-010 i_rst  input  1  reset; synchronous and active-high.
REQ-011 clk_en  input  1  write strobe from the custom instruction; one cycle per write.
REQ-012 sel  input  3  index of the bar written on clk_en.
REQ-013 coordY  input  10  requested top-edge y for the selected bar.
REQ-014 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-015 o_active  input  1  high while the scanout is in the visible area.
REQ-016 o_x  input  11  current pixel x.
REQ-017 o_y  input  10  current pixel y.
REQ-018 wr_ack  output  1  one-cycle pulse acknowledging a write.
REQ-019 wr_err  output  1  one-cycle pulse, with wr_ack, when sel >= N_BARS.
REQ-020 pending  output  N_BARS  bit i high while bar i has an uncommitted target.
REQ-021 color  output  1  registered pixel-on flag.
REQ-022 bar_hit  output  3  registered index of the bar drawn at the pixel; 0 when color = 0.

Function
REQ-023 On clk_en with sel < N_BARS, the block SHALL store min(coordY, Y_MAX) into target[sel] and set pending[sel] in the next cycle.
REQ-024 The block SHALL pulse wr_ack exactly one cycle after every clk_en; on sel >= N_BARS it SHALL also pulse wr_err and change no state.
REQ-025 A write to a bar whose pending bit is already set SHALL overwrite target; the last write before a frame_start wins.
REQ-026 Active y[i] SHALL change only in the cycle after frame_start, never during visible scanout.
REQ-027 SLEW_MODE=0: on frame_start, each pending bar SHALL set y[i] = target[i] and clear pending[i].
REQ-028 SLEW_MODE=1: on frame_start, each pending bar SHALL move y[i] toward target[i] by min(STEP, |target-y|) and clear pending[i] only when y[i] equals target[i] after the move.
REQ-029 If clk_en and frame_start occur in the same cycle for the same bar, the commit SHALL use the target held before that cycle; the new write stays pending for the next frame.
REQ-030 Bar i covers o_x in [X_i, X_i+BAR_W-1] and o_y in [y[i], y[i]+BAR_H-1], inclusive; comparisons SHALL use 12-bit sums so there is no wrap-around.
REQ-031 color SHALL be 1 one cycle after a pixel with o_active=1 that lies inside any bar, and 0 otherwise; o_active=0 SHALL always give color 0.
REQ-032 Where bars overlap, bar_hit SHALL report the lowest index.
REQ-033 Pixel path latency SHALL be exactly one clk_in cycle, independent of writes and commits.

Reset
REQ-034 While i_rst=1 at a clock edge, the block SHALL set y[i]=Y_INIT and target[i]=Y_INIT for all i, and pending=0, color=0, bar_hit=0, wr_ack=0, wr_err=0.
REQ-035 Reset during a pending or slewing move SHALL discard the move; clk_en and frame_start SHALL be ignored in the reset cycle.

Verification
REQ-036 Defaults: after reset, pixel (12,290) with o_active=1 -> color=1 and bar_hit=0 next cycle; pixel (12,315) -> color=0.
REQ-037 Write: sel=1, coordY=100 -> wr_ack pulse and pending=2'b10; y[1] stays 285 until frame_start; one cycle after frame_start, pixel (625,100) -> color=1 and bar_hit=1, and pending=0.
REQ-038 Clamp and error: coordY=700 on sel=0 -> target 450 and bar drawn at rows 450..479 after commit; sel=5 -> wr_ack and wr_err pulse, pending unchanged.
REQ-039 Slew: SLEW_MODE=1, STEP=4, y=285, write 295 -> after successive frame_start pulses y = 289, 293, 295; pending clears on the third.
REQ-040 Collision: clk_en (sel=0, 50) in the same cycle as frame_start while target[0]=200 is pending -> y[0]=200 and pending[0] stays 1; the next frame_start gives y[0]=50.
REQ-041 Reset mid-slew and blanking: i_rst during a slew -> y back to 285 and pending=0; o_active=0 at (12,290) -> color=0.
